// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator key-entry front end: key codes,
// operator encodings seen by the BCD ALU, the entry state machine states and
// the digit-shifter direction.
// -----------------------------------------------------------------------------
package calc_pkg;

  // Non-digit key codes (digits are 0x0..0x9).
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_BS  = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_NOP = 4'hF;

  // Operator encoding presented to the ALU.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10
  } op_t;

  // Entry sequencing states.
  typedef enum logic [1:0] {
    ENTER_A,
    OP_WAIT,
    ENTER_B,
    SHOW_RESULT
  } state_t;

  // Digit shifter operation: append a digit, or drop the least significant one.
  typedef enum logic {
    SHIFT_IN,
    SHIFT_OUT
  } shift_dir_t;

endpackage

// File: rtl/calc_key_entry_if.sv
// -----------------------------------------------------------------------------
// calc_key_entry_if
// Operand/operator bus between the key-entry block and the BCD ALU.
//   bcd1, bcd2   : packed-BCD operands A and B (key entry -> ALU)
//   op_selected  : 00 none, 01 add, 10 subtract (key entry -> ALU)
//   alu_clear    : active-high clear (key entry -> ALU)
//   alu_bcd      : BCD result magnitude (ALU -> key entry, combinational)
//   alu_neg      : sign, 1 = result is bcd2-bcd1 magnitude (ALU -> key entry)
// Modports: master = key-entry side, slave = ALU side.
// -----------------------------------------------------------------------------
interface calc_key_entry_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd1;
  logic [4*DIGITS-1:0] bcd2;
  logic [1:0]          op_selected;
  logic                alu_clear;
  logic [4*DIGITS-1:0] alu_bcd;
  logic                alu_neg;

  modport master (
    output bcd1, bcd2, op_selected, alu_clear,
    input  alu_bcd, alu_neg
  );

  modport slave (
    input  bcd1, bcd2, op_selected, alu_clear,
    output alu_bcd, alu_neg
  );
endinterface

// File: rtl/bcd_digit_shifter.sv
// -----------------------------------------------------------------------------
// bcd_digit_shifter
// Combinational next-value logic for one packed-BCD operand register and its
// significant-digit counter. The top instantiates it once and muxes the active
// operand (bcd1 or bcd2) through it.
//   i_dir      : SHIFT_IN appends i_digit, SHIFT_OUT drops the lowest digit
//   i_operand  : current operand value
//   i_count    : current number of significant digits
//   i_digit    : digit to append (SHIFT_IN only)
//   o_operand  : next operand value
//   o_count    : next digit count
//   o_err      : operand already full, digit rejected
// Requires DIGITS >= 2.
// -----------------------------------------------------------------------------
module bcd_digit_shifter
  import calc_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  shift_dir_t       i_dir,
  input  logic [W-1:0]     i_operand,
  input  logic [CNT_W-1:0] i_count,
  input  logic [3:0]       i_digit,
  output logic [W-1:0]     o_operand,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
);

  // NOTE: every output gets a default before any branch so no path leaves a
  // value unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    o_operand = i_operand;
    o_count   = i_count;
    o_err     = 1'b0;
    if (i_dir == SHIFT_IN) begin
      if (i_count == CNT_W'(DIGITS)) begin
        o_err = 1'b1;
      end else if (!(i_operand == '0 && i_digit == 4'h0)) begin
        // A zero into an empty operand would only be a leading zero.
        o_operand = {i_operand[W-5:0], i_digit};
        o_count   = i_count + 1'b1;
      end
    end else begin
      o_operand = {4'h0, i_operand[W-1:4]};
      if (i_count != '0) begin
        o_count = i_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// -----------------------------------------------------------------------------
// calc_key_entry
// Keypad front end of the calculator. Accumulates decimal keys into two
// packed-BCD operands, latches the operator, sequences entry -> result display,
// chains a non-negative result into the next operation, and selects what the
// display shows. All outputs are registered.
//
// Optional feature: define CALC_BACKSPACE_EN to enable key 0xD (backspace).
// Without it 0xD is ignored like 0xF.
//
// Ports:
//   clk          : system clock, rising edge
//   clear_n      : asynchronous active-low reset
//   key_valid    : one-cycle strobe qualifying key_code
//   key_code     : 0-9 digit, A add, B sub, C clear, D backspace, E equals
//   alu          : ALU bus (master side): bcd1/bcd2/op_selected/alu_clear
//                  out, alu_bcd/alu_neg in
//   disp_bcd     : value for the display driver
//   disp_neg     : display minus sign
//   result_valid : high while a computed result is shown
//   err          : one-cycle pulse on a rejected key
// -----------------------------------------------------------------------------
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int KEY_W  = 4
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                key_valid,
  input  logic [KEY_W-1:0]    key_code,
  calc_key_entry_if.master    alu,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                disp_neg,
  output logic                result_valid,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

`ifdef CALC_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  // Number of significant digits in a BCD value; used when a chained result
  // becomes operand A so later edits count correctly.
  function automatic logic [CNT_W-1:0] sig_digits(input logic [W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) n = CNT_W'(i + 1);
    end
    return n;
  endfunction

  state_t           r_state;
  logic [W-1:0]     r_bcd1;
  logic [W-1:0]     r_bcd2;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  op_t              r_op;
  logic             r_alu_clear;
  logic             r_err;
  logic             r_result_valid;
  logic [W-1:0]     r_disp_bcd;
  logic             r_disp_neg;

  // Key decode.
  logic       w_is_digit;
  logic       w_is_op;
  logic       w_is_clr;
  logic       w_is_eq;
  logic       w_is_bs;
  logic [3:0] w_digit;
  op_t        w_key_op;

  assign w_is_digit = (key_code <= KEY_W'(9));
  assign w_is_op    = (key_code == KEY_W'(KEY_ADD)) || (key_code == KEY_W'(KEY_SUB));
  assign w_is_clr   = (key_code == KEY_W'(KEY_CLR));
  assign w_is_eq    = (key_code == KEY_W'(KEY_EQ));
  assign w_is_bs    = BS_EN && (key_code == KEY_W'(KEY_BS));
  assign w_digit    = key_code[3:0];
  assign w_key_op   = (key_code == KEY_W'(KEY_ADD)) ? OP_ADD : OP_SUB;

  // Shared shifter works on whichever operand is being edited.
  shift_dir_t       w_sh_dir;
  logic [W-1:0]     w_sh_operand_in;
  logic [CNT_W-1:0] w_sh_count_in;
  logic [W-1:0]     w_sh_operand;
  logic [CNT_W-1:0] w_sh_count;
  logic             w_sh_err;

  assign w_sh_dir        = w_is_bs ? SHIFT_OUT : SHIFT_IN;
  assign w_sh_operand_in = (r_state == ENTER_B) ? r_bcd2  : r_bcd1;
  assign w_sh_count_in   = (r_state == ENTER_B) ? r_cnt_b : r_cnt_a;

  bcd_digit_shifter #(
    .DIGITS (DIGITS)
  ) u_shifter (
    .i_dir     (w_sh_dir),
    .i_operand (w_sh_operand_in),
    .i_count   (w_sh_count_in),
    .i_digit   (w_digit),
    .o_operand (w_sh_operand),
    .o_count   (w_sh_count),
    .o_err     (w_sh_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state        <= ENTER_A;
      r_bcd1         <= '0;
      r_bcd2         <= '0;
      r_cnt_a        <= '0;
      r_cnt_b        <= '0;
      r_op           <= OP_NONE;
      r_alu_clear    <= 1'b1;
      r_err          <= 1'b0;
      r_result_valid <= 1'b0;
      r_disp_bcd     <= '0;
      r_disp_neg     <= 1'b0;
    end else begin
      r_err       <= 1'b0;
      r_alu_clear <= 1'b0;

      // Display follows the current state and operands one cycle later.
      case (r_state)
        ENTER_B:     r_disp_bcd <= r_bcd2;
        SHOW_RESULT: r_disp_bcd <= alu.alu_bcd;
        default:     r_disp_bcd <= r_bcd1;
      endcase
      r_disp_neg <= (r_state == SHOW_RESULT) && alu.alu_neg;

      if (key_valid) begin
        if (w_is_clr) begin
          r_state        <= ENTER_A;
          r_bcd1         <= '0;
          r_bcd2         <= '0;
          r_cnt_a        <= '0;
          r_cnt_b        <= '0;
          r_op           <= OP_NONE;
          r_alu_clear    <= 1'b1;
          r_result_valid <= 1'b0;
        end else begin
          case (r_state)
            ENTER_A: begin
              if (w_is_digit || w_is_bs) begin
                r_bcd1  <= w_sh_operand;
                r_cnt_a <= w_sh_count;
                r_err   <= w_sh_err;
              end else if (w_is_op) begin
                r_op    <= w_key_op;
                r_state <= OP_WAIT;
              end
            end

            OP_WAIT: begin
              if (w_is_digit) begin
                r_bcd2  <= W'(w_digit);
                r_cnt_b <= (w_digit != 4'h0) ? CNT_W'(1) : '0;
                r_state <= ENTER_B;
              end else if (w_is_op) begin
                r_op <= w_key_op;
              end else if (w_is_bs) begin
                r_op    <= OP_NONE;
                r_state <= ENTER_A;
              end
            end

            ENTER_B: begin
              if (w_is_digit || w_is_bs) begin
                r_bcd2  <= w_sh_operand;
                r_cnt_b <= w_sh_count;
                r_err   <= w_sh_err;
              end else if (w_is_eq) begin
                r_state        <= SHOW_RESULT;
                r_result_valid <= 1'b1;
              end else if (w_is_op) begin
                r_err <= 1'b1;
              end
            end

            SHOW_RESULT: begin
              if (w_is_op) begin
                if (alu.alu_neg) begin
                  // A negative result cannot be an operand.
                  r_err <= 1'b1;
                end else begin
                  r_bcd1         <= alu.alu_bcd;
                  r_cnt_a        <= sig_digits(alu.alu_bcd);
                  r_bcd2         <= '0;
                  r_cnt_b        <= '0;
                  r_op           <= w_key_op;
                  r_state        <= OP_WAIT;
                  r_result_valid <= 1'b0;
                end
              end else if (w_is_digit) begin
                r_bcd1         <= W'(w_digit);
                r_cnt_a        <= (w_digit != 4'h0) ? CNT_W'(1) : '0;
                r_bcd2         <= '0;
                r_cnt_b        <= '0;
                r_op           <= OP_NONE;
                r_state        <= ENTER_A;
                r_result_valid <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  assign alu.bcd1        = r_bcd1;
  assign alu.bcd2        = r_bcd2;
  assign alu.op_selected = r_op;
  assign alu.alu_clear   = r_alu_clear;
  assign disp_bcd        = r_disp_bcd;
  assign disp_neg        = r_disp_neg;
  assign result_valid    = r_result_valid;
  assign err             = r_err;

endmodule
